// File: rtl/invader_formation_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// invader_formation_ctrl_pkg
//   Shared types and helpers for the invader formation controller.
//   - formation_state_t : IDLE / MARCH / HALT controller states
//   - dir_t             : horizontal march direction
//   - popcount32        : counts set bits of a (zero-extended) alive mask
// ----------------------------------------------------------------------------
package invader_formation_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARCH = 2'd1,
    HALT  = 2'd2
  } formation_state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  // Masks narrower than 32 bits are zero-extended by the caller.
  function automatic logic [5:0] popcount32(input logic [31:0] m);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, m[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/invader_formation_ctrl_if.sv
// ----------------------------------------------------------------------------
// invader_formation_ctrl_if
//   Hit-report channel between the collision logic (master) and the
//   formation controller (slave).
//   hit_valid  : 1-cycle pulse, invader hit_index was struck
//   hit_index  : index of the struck invader
//   hit_ack    : 1-cycle pulse, the cycle after hit_valid
//   hit_ok     : qualifies hit_ack; 1 = invader was alive and is now removed
// ----------------------------------------------------------------------------
interface invader_formation_ctrl_if #(
  parameter int NUM_INVADERS = 10
);
  localparam int IDX_W = (NUM_INVADERS > 1) ? $clog2(NUM_INVADERS) : 1;

  logic             hit_valid;
  logic [IDX_W-1:0] hit_index;
  logic             hit_ack;
  logic             hit_ok;

  modport master (output hit_valid, output hit_index, input hit_ack, input hit_ok);
  modport slave  (input hit_valid, input hit_index, output hit_ack, output hit_ok);

endinterface

// File: rtl/invader_formation_ctrl_step_timer.sv
// ----------------------------------------------------------------------------
// invader_formation_ctrl_step_timer
//   8-bit frame down-counter that paces formation steps.
//   clk         : pixel clock
//   rst         : synchronous, active-high reset (count -> 0)
//   load_i      : load load_val_i (wins over tick_i)
//   load_val_i  : reload value
//   tick_i      : decrement by one, saturating at zero
//   expired_o   : count is zero, the next tick is a step
// ----------------------------------------------------------------------------
module invader_formation_ctrl_step_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic       expired_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: load beats tick, tick never underflows.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == 8'd0);

endmodule

// File: rtl/invader_formation_ctrl.sv
// ----------------------------------------------------------------------------
// invader_formation_ctrl
//   Motion and state source for the invader row. Marches the row left/right,
//   drops it at the edges, removes invaders on hit reports and publishes the
//   visible alive mask only on frame_tick so a frame never shows a torn row.
//   clk65MHz        : pixel clock
//   rst             : synchronous, active-high reset
//   frame_tick      : 1-cycle pulse at start of vblank
//   game_start      : 1-cycle pulse, (re)initialise and start marching
//   hit             : hit-report channel (slave side)
//   xpos / ypos     : formation offsets
//   invader_enable  : alive mask as shown on screen
//   all_destroyed   : sticky until game_start/rst
//   reached_bottom  : sticky until game_start/rst
// ----------------------------------------------------------------------------
module invader_formation_ctrl
  import invader_formation_ctrl_pkg::*;
#(
  parameter int NUM_INVADERS     = 10,
  parameter int X_MAX_OFFSET     = 100,
  parameter int Y_MAX_OFFSET     = 400,
  parameter int STEP_X           = 4,
  parameter int STEP_Y           = 16,
  parameter int MOVE_PERIOD_MIN  = 2,
  parameter int PERIOD_PER_ALIVE = 3
) (
  input  logic                      clk65MHz,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      game_start,
  invader_formation_ctrl_if.slave   hit,
  output logic [9:0]                xpos,
  output logic [9:0]                ypos,
  output logic [NUM_INVADERS-1:0]   invader_enable,
  output logic                      all_destroyed,
  output logic                      reached_bottom
);

  localparam int IDX_W = (NUM_INVADERS > 1) ? $clog2(NUM_INVADERS) : 1;

  localparam logic [10:0]             X_MAX11     = 11'(X_MAX_OFFSET);
  localparam logic [10:0]             Y_MAX11     = 11'(Y_MAX_OFFSET);
  localparam logic [10:0]             STEP_X11    = 11'(STEP_X);
  localparam logic [10:0]             STEP_Y11    = 11'(STEP_Y);
  localparam logic [IDX_W:0]          NUM_IDX     = (IDX_W + 1)'(NUM_INVADERS);
  localparam logic [7:0]              FULL_RELOAD = 8'(MOVE_PERIOD_MIN + NUM_INVADERS * PERIOD_PER_ALIVE - 1);
  localparam logic [NUM_INVADERS-1:0] ALL_ALIVE   = {NUM_INVADERS{1'b1}};
  localparam logic [NUM_INVADERS-1:0] ONE_HOT0    = {{(NUM_INVADERS-1){1'b0}}, 1'b1};

  // Registers
  formation_state_t          state_q, state_d;
  dir_t                      dir_q, dir_d;
  logic [9:0]                xpos_q, xpos_d;
  logic [9:0]                ypos_q, ypos_d;
  logic [NUM_INVADERS-1:0]   pending_q, pending_d;
  logic [NUM_INVADERS-1:0]   enable_q, enable_d;
  logic                      alld_q, alld_d;
  logic                      bot_q, bot_d;
  logic                      hit_ack_q, hit_ack_d;
  logic                      hit_ok_q, hit_ok_d;

  // Combinational helpers
  logic                      hit_accept_s;
  logic [NUM_INVADERS-1:0]   pending_hit_s;
  logic                      march_tick_s;
  logic                      none_left_s;
  logic [5:0]                alive_cnt_s;
  logic [7:0]                reload_s;
  logic                      timer_expired_s;
  logic                      timer_load_s;
  logic [7:0]                timer_val_s;
  logic                      timer_tick_s;
  logic                      step_s;
  logic [10:0]                x_ext_s;
  logic [10:0]                y_drop_s;
  logic [10:0]                x_right_s;
  logic                      drop_s;
  logic                      bottom_s;

  // Hit acceptance and the post-hit mask; game_start and HALT swallow hits.
  always_comb begin
    hit_accept_s  = 1'b0;
    pending_hit_s = pending_q;
    if (hit.hit_valid && !game_start && (state_q != HALT) &&
        ({1'b0, hit.hit_index} < NUM_IDX)) begin
      hit_accept_s  = pending_q[hit.hit_index];
      pending_hit_s = pending_q & ~(ONE_HOT0 << hit.hit_index);
    end else begin
      hit_accept_s  = 1'b0;
      pending_hit_s = pending_q;
    end
  end

  // Step pacing: the period is taken from the mask including a same-cycle hit.
  always_comb begin
    march_tick_s = (state_q == MARCH) && frame_tick && !game_start;
    none_left_s  = (pending_hit_s == {NUM_INVADERS{1'b0}});
    alive_cnt_s  = popcount32(32'(pending_hit_s));
    reload_s     = 8'(MOVE_PERIOD_MIN) + 8'(alive_cnt_s) * 8'(PERIOD_PER_ALIVE) - 8'd1;
    step_s       = march_tick_s && !none_left_s && timer_expired_s;
    timer_tick_s = march_tick_s && !none_left_s;
    timer_load_s = game_start || step_s;
    timer_val_s  = game_start ? FULL_RELOAD : reload_s;
  end

  // Edge geometry in 11 bits so the comparisons cannot wrap.
  always_comb begin
    x_ext_s   = {1'b0, xpos_q};
    x_right_s = x_ext_s + STEP_X11;
    y_drop_s  = {1'b0, ypos_q} + STEP_Y11;
    bottom_s  = (y_drop_s >= Y_MAX11);
    if (dir_q == DIR_RIGHT) begin
      drop_s = (x_right_s > X_MAX11);
    end else begin
      drop_s = (x_ext_s < STEP_X11);
    end
  end

  invader_formation_ctrl_step_timer u_step_timer (
    .clk        (clk65MHz),
    .rst        (rst),
    .load_i     (timer_load_s),
    .load_val_i (timer_val_s),
    .tick_i     (timer_tick_s),
    .expired_o  (timer_expired_s)
  );

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (game_start) begin
      state_d = MARCH;
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        MARCH: begin
          if (march_tick_s && none_left_s) begin
            state_d = HALT;
          end else if (step_s && drop_s && bottom_s) begin
            state_d = HALT;
          end else begin
            state_d = MARCH;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    dir_d     = dir_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    pending_d = pending_q;
    enable_d  = enable_q;
    alld_d    = alld_q;
    bot_d     = bot_q;
    hit_ack_d = hit.hit_valid;
    hit_ok_d  = hit_accept_s;
    if (game_start) begin
      dir_d     = DIR_RIGHT;
      xpos_d    = 10'd0;
      ypos_d    = 10'd0;
      pending_d = ALL_ALIVE;
      enable_d  = ALL_ALIVE;
      alld_d    = 1'b0;
      bot_d     = 1'b0;
    end else begin
      pending_d = pending_hit_s;
      // The visible mask only changes at vblank.
      if (frame_tick && (state_q != HALT)) begin
        enable_d = pending_hit_s;
      end else begin
        enable_d = enable_q;
      end
      if (march_tick_s && none_left_s) begin
        alld_d = 1'b1;
      end else begin
        alld_d = alld_q;
      end
      if (step_s && drop_s) begin
        ypos_d = y_drop_s[9:0];
        dir_d  = (dir_q == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
        bot_d  = bot_q | bottom_s;
      end else if (step_s) begin
        xpos_d = (dir_q == DIR_RIGHT) ? x_right_s[9:0] : (xpos_q - 10'(STEP_X));
      end else begin
        xpos_d = xpos_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= DIR_RIGHT;
      xpos_q    <= 10'd0;
      ypos_q    <= 10'd0;
      pending_q <= ALL_ALIVE;
      enable_q  <= ALL_ALIVE;
      alld_q    <= 1'b0;
      bot_q     <= 1'b0;
      hit_ack_q <= 1'b0;
      hit_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      alld_q    <= alld_d;
      bot_q     <= bot_d;
      hit_ack_q <= hit_ack_d;
      hit_ok_q  <= hit_ok_d;
    end
  end

  assign xpos           = xpos_q;
  assign ypos           = ypos_q;
  assign invader_enable = enable_q;
  assign all_destroyed  = alld_q;
  assign reached_bottom = bot_q;
  assign hit.hit_ack    = hit_ack_q;
  assign hit.hit_ok     = hit_ok_q;

endmodule

// File: tb/tb_invader_formation_ctrl.sv
// ----------------------------------------------------------------------------
// tb_invader_formation_ctrl
//   Scoreboard bench: every driven cycle pushes the expected outputs from a
//   small behavioural model, which are popped and compared one clock later.
//   Y_MAX_OFFSET is 32 so the bottom is reached on the second drop.
// ----------------------------------------------------------------------------
module tb_invader_formation_ctrl;

  localparam int N    = 10;
  localparam int XMAX = 100;
  localparam int YMAX = 32;
  localparam int SX   = 4;
  localparam int SY   = 16;
  localparam int PMIN = 2;
  localparam int PPER = 3;

  logic          clk65MHz = 1'b0;
  logic          rst = 1'b0;
  logic          frame_tick = 1'b0;
  logic          game_start = 1'b0;
  logic [9:0]    xpos, ypos;
  logic [N-1:0]  invader_enable;
  logic          all_destroyed, reached_bottom;

  always #5 clk65MHz = ~clk65MHz;

  invader_formation_ctrl_if #(.NUM_INVADERS(N)) hit_if ();

  invader_formation_ctrl #(
    .NUM_INVADERS(N), .X_MAX_OFFSET(XMAX), .Y_MAX_OFFSET(YMAX),
    .STEP_X(SX), .STEP_Y(SY), .MOVE_PERIOD_MIN(PMIN), .PERIOD_PER_ALIVE(PPER)
  ) dut (
    .clk65MHz       (clk65MHz),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .game_start     (game_start),
    .hit            (hit_if.slave),
    .xpos           (xpos),
    .ypos           (ypos),
    .invader_enable (invader_enable),
    .all_destroyed  (all_destroyed),
    .reached_bottom (reached_bottom)
  );

  typedef struct {
    logic         ack;
    logic         ok;
    int           x;
    int           y;
    logic [N-1:0] en;
    logic         alld;
    logic         bot;
  } exp_t;

  exp_t exp_q[$];

  // Reference model (0 = IDLE, 1 = MARCH, 2 = HALT; dir 0 = right)
  int           m_state, m_x, m_y, m_cnt;
  bit           m_dir, m_alld, m_bot;
  logic [N-1:0] m_pend, m_en;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int popc(input logic [N-1:0] m);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = 0; m_y = 0; m_cnt = 0; m_dir = 1'b0;
    m_alld = 1'b0; m_bot = 1'b0; m_pend = '1; m_en = '1;
  endtask

  task automatic model_march_tick();
    bit drop;
    m_en = m_pend;
    if (m_pend == '0) begin
      m_alld = 1'b1;
      m_state = 2;
    end else if (m_cnt != 0) begin
      m_cnt--;
    end else begin
      m_cnt = PMIN + popc(m_pend) * PPER - 1;
      drop = 1'b0;
      if (m_dir == 1'b0) begin
        if (m_x + SX > XMAX) drop = 1'b1; else m_x += SX;
      end else begin
        if (m_x < SX) drop = 1'b1; else m_x -= SX;
      end
      if (drop) begin
        m_y += SY;
        m_dir = ~m_dir;
        if (m_y >= YMAX) begin
          m_bot = 1'b1;
          m_state = 2;
        end
      end
    end
  endtask

  // One clock of stimulus: model update, push expectation, clock, pop and compare.
  task automatic apply(input bit r, input bit start, input bit tick, input bit hv, input int idx);
    exp_t e, o;
    bit ok;
    rst = r; game_start = start; frame_tick = tick;
    hit_if.hit_valid = hv; hit_if.hit_index = 4'(idx);
    ok = 1'b0;
    if (r) begin
      model_reset();
      e.ack = 1'b0;
    end else begin
      ok = hv && !start && (m_state != 2) && (idx < N) && m_pend[idx];
      e.ack = hv;
      if (start) begin
        m_x = 0; m_y = 0; m_pend = '1; m_en = '1; m_dir = 1'b0;
        m_alld = 1'b0; m_bot = 1'b0; m_cnt = PMIN + N * PPER - 1; m_state = 1;
      end else begin
        if (ok) m_pend[idx] = 1'b0;
        if (tick && m_state == 0) m_en = m_pend;
        if (tick && m_state == 1) model_march_tick();
      end
    end
    e.ok = ok; e.x = m_x; e.y = m_y; e.en = m_en; e.alld = m_alld; e.bot = m_bot;
    exp_q.push_back(e);
    @(posedge clk65MHz);
    #1;
    rst = 1'b0; game_start = 1'b0; frame_tick = 1'b0; hit_if.hit_valid = 1'b0;
    o = exp_q.pop_front();
    check_eq("hit_ack", 32'(hit_if.hit_ack), 32'(o.ack));
    check_eq("hit_ok", 32'(hit_if.hit_ok), 32'(o.ok));
    check_eq("xpos", 32'(xpos), o.x);
    check_eq("ypos", 32'(ypos), o.y);
    check_eq("invader_enable", 32'(invader_enable), 32'(o.en));
    check_eq("all_destroyed", 32'(all_destroyed), 32'(o.alld));
    check_eq("reached_bottom", 32'(reached_bottom), 32'(o.bot));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic hit(input int idx);
    apply(1'b0, 1'b0, 1'b0, 1'b1, idx);
  endtask

  initial begin
    int guard;
    hit_if.hit_valid = 1'b0;
    hit_if.hit_index = 4'd0;
    model_reset();

    // Reset state
    apply(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_eq("rst_enable", 32'(invader_enable), 32'h3FF);

    // T1: first step after 32 frames
    apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
    ticks(31);
    check_eq("t1_x_after31", 32'(xpos), 32'd0);
    ticks(1);
    check_eq("t1_x_after32", 32'(xpos), 32'd4);

    // T2: right edge, drop, then first left step
    ticks(24 * 32);
    check_eq("t2_x_edge", 32'(xpos), 32'd100);
    ticks(32);
    check_eq("t2_drop_y", 32'(ypos), 32'd16);
    check_eq("t2_drop_x", 32'(xpos), 32'd100);
    ticks(32);
    check_eq("t2_left_x", 32'(xpos), 32'd96);

    // T3: hit index 3 is held back until the next frame tick
    hit(3);
    check_eq("t3_en3_before_tick", 32'(invader_enable[3]), 32'd1);
    ticks(1);
    check_eq("t3_en3_after_tick", 32'(invader_enable[3]), 32'd0);
    hit(3);
    hit(12);
    ticks(31);
    check_eq("t3_step_x", 32'(xpos), 32'd92);
    ticks(28);
    check_eq("t3_no_step_x", 32'(xpos), 32'd92);
    ticks(1);
    check_eq("t3_period29_x", 32'(xpos), 32'd88);

    // T5: march to the second drop, bottom reached
    guard = 0;
    while (m_state == 1 && guard < 3000) begin
      ticks(1);
      guard++;
    end
    check_eq("t5_model_halted", 32'(m_state), 32'd2);
    check_eq("t5_y", 32'(ypos), 32'd32);
    check_eq("t5_x", 32'(xpos), 32'd0);
    check_eq("t5_reached_bottom", 32'(reached_bottom), 32'd1);
    hit(5);
    ticks(5);

    // T6: game_start wins over a same-cycle hit in HALT
    apply(1'b0, 1'b1, 1'b0, 1'b1, 5);
    check_eq("t6_enable", 32'(invader_enable), 32'h3FF);
    check_eq("t6_bottom_clr", 32'(reached_bottom), 32'd0);

    // T4: one alive -> period 5, last hit on a frame tick -> all destroyed
    for (int i = 0; i < 9; i++) hit(i);
    check_eq("t4_enable_held", 32'(invader_enable), 32'h3FF);
    ticks(32);
    check_eq("t4_first_step", 32'(xpos), 32'd4);
    ticks(4);
    check_eq("t4_hold", 32'(xpos), 32'd4);
    ticks(1);
    check_eq("t4_period5", 32'(xpos), 32'd8);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 9);
    check_eq("t4_all_destroyed", 32'(all_destroyed), 32'd1);
    check_eq("t4_enable_zero", 32'(invader_enable), 32'd0);
    ticks(100);
    check_eq("t4_frozen_x", 32'(xpos), 32'd8);
    check_eq("t4_frozen_y", 32'(ypos), 32'd0);

    // T6: rst mid-MARCH beats a simultaneous game_start/tick
    apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
    ticks(40);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 2);
    check_eq("t6_rst_x", 32'(xpos), 32'd0);
    check_eq("t6_rst_ack", 32'(hit_if.hit_ack), 32'd0);
    ticks(40);
    check_eq("t6_idle_no_move", 32'(xpos), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
